// File: rtl/char_stream_feeder.sv
// Byte FIFO feeding the `string` recognizer: classifies each character and inserts a
// one-cycle frame gap after every ';'. Optional macro STRIP_WS_EN drops whitespace on write.
module char_stream_feeder #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] out_class,
  input  logic       out_ready,
  output logic       frame_done,
  output logic [7:0] frame_len,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q;
  logic [7:0]        len_q, len_d;
  logic [7:0]        frame_len_q, frame_len_d;
  logic [7:0]        drop_q, drop_d;

  logic       wr_en, rd_en, store, drop, is_ws;
  logic [7:0] len_inc;

`ifdef STRIP_WS_EN
  assign is_ws = (in_data == 8'h20) || (in_data == 8'h09) ||
                 (in_data == 8'h0A) || (in_data == 8'h0D);
`else
  assign is_ws = 1'b0;
`endif

  assign in_ready = ~full_q & ~clr;
  assign wr_en    = in_valid & in_ready;
  assign drop     = wr_en & in_data[7];
  assign store    = wr_en & ~in_data[7] & ~is_ws;

  // clr also hides the head so the recognizer sees idle while buffers are being flushed
  assign out_valid  = (count_q != '0) & (state_q != StGap) & ~clr;
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : IDLE_CHAR;
  assign rd_en      = out_valid & out_ready;
  assign frame_done = (state_q == StGap);
  assign frame_len  = frame_len_q;
  assign drop_cnt   = drop_q;

  always_comb begin
    out_class = 2'b00;
    if (out_valid) begin
      if (out_data >= 8'h30 && out_data <= 8'h39) begin
        out_class = 2'b01;
      end else if (out_data == 8'h2B || out_data == 8'h2D ||
                   out_data == 8'h2A || out_data == 8'h2F) begin
        out_class = 2'b10;
      end else if (out_data == 8'h3B) begin
        out_class = 2'b11;
      end
    end
  end

  assign len_inc = (len_q == 8'hFF) ? len_q : len_q + 8'd1;

  always_comb begin
    count_d     = count_q;
    state_d     = state_q;
    len_d       = len_q;
    frame_len_d = frame_len_q;
    drop_d      = drop_q;

    unique case ({store, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end

    if (rd_en) begin
      len_d = len_inc;
      if (out_class == 2'b11) begin
        frame_len_d = len_inc;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (store) state_d = StRun;
      end
      StRun: begin
        if (rd_en && out_class == 2'b11) begin
          state_d = StGap;
        end else if (count_d == '0) begin
          state_d = StIdle;
        end
      end
      StGap: begin
        len_d   = 8'd0;
        state_d = (count_d != '0) ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      len_q       <= 8'd0;
      frame_len_q <= 8'd0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      full_q      <= (count_d == FullCount);
      len_q       <= len_d;
      frame_len_q <= frame_len_d;
      drop_q      <= drop_d;
      if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_char_stream_feeder.sv
// Self-checking bench for char_stream_feeder: queue-based reference model plus directed
// scenarios and a randomized run. Honours STRIP_WS_EN for whitespace expectations.
module tb_char_stream_feeder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_class;
  logic       out_ready = 1'b0;
  logic       frame_done;
  logic [7:0] frame_len;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  char_stream_feeder #(.DEPTH(8), .ADDR_W(3), .IDLE_CHAR(8'h00)) dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_class  (out_class),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .drop_cnt   (drop_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the FIFO contents, a pending-gap flag and the counters.
  logic [7:0] mq[$];
  bit         m_gap = 0;
  int         m_len = 0;
  int         m_flen = 0;
  int         m_drop = 0;

  logic        exp_valid, exp_ready;
  logic [28:0] exp_vec;
  logic [28:0] obs;
  assign obs = {out_valid, out_data, out_class, in_ready, frame_done, frame_len, drop_cnt};

  function automatic logic [1:0] cls(input logic [7:0] b);
    if (b >= "0" && b <= "9") return 2'b01;
    if (b == "+" || b == "-" || b == "*" || b == "/") return 2'b10;
    if (b == ";") return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit is_ws(input logic [7:0] b);
`ifdef STRIP_WS_EN
    return (b == 8'h20 || b == 8'h09 || b == 8'h0A || b == 8'h0D);
`else
    return (b != b);
`endif
  endfunction

  // Apply inputs for this cycle and derive what the DUT should present.
  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic [7:0] hd;
    logic [1:0] hc;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr       = c;
    #1;
    exp_ready = !c && (mq.size() < DEPTH);
    exp_valid = !c && (mq.size() != 0) && !m_gap;
    hd = exp_valid ? mq[0] : 8'h00;
    hc = exp_valid ? cls(mq[0]) : 2'b00;
    exp_vec = {exp_valid, hd, hc, exp_ready, m_gap, 8'(m_flen), 8'(m_drop)};
  endtask

  // Apply the clock edge to the model, then move to the next sampling point.
  task automatic advance();
    logic [7:0] hb;
    if (clr) begin
      mq.delete();
      m_gap = 0; m_len = 0; m_flen = 0; m_drop = 0;
    end else begin
      if (m_gap) begin
        m_gap = 0;
        m_len = 0;
      end else if (exp_valid && out_ready) begin
        hb = mq.pop_front();
        m_len = (m_len < 255) ? m_len + 1 : 255;
        if (hb == ";") begin
          m_flen = m_len;
          m_gap  = 1;
        end
      end
      if (in_valid && exp_ready) begin
        if (in_data[7]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else if (!is_ws(in_data)) mq.push_back(in_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    advance();
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_during_clr: ready=%b valid=%b required 0 0", in_ready, out_valid);
    end
    advance();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== {1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 8'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_state: got %h required %h", obs, {1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 8'd0, 8'd0});
    end
    advance();
  endtask

  task automatic test_frame();
    logic [7:0] s [4] = '{8'h31, 8'h2B, 8'h31, 8'h3B};
    logic [1:0] c [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
    pulse_clr();
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, (i < 4) ? s[i] : 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL frame_model c%0d: got %h required %h", i, obs, exp_vec);
      end
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== s[i-1] || out_class !== c[i-1]) begin
          n_err++;
          $display("FAIL frame_char c%0d: got %b %h %b required 1 %h %b",
                   i, out_valid, out_data, out_class, s[i-1], c[i-1]);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || frame_done !== 1'b1 || frame_len !== 8'd4) begin
          n_err++;
          $display("FAIL frame_gap: got %b %h %b %0d required 0 00 1 4",
                   out_valid, out_data, frame_done, frame_len);
        end
      end
      advance();
    end
  endtask

  task automatic test_full();
    logic [7:0] got[$];
    bit accepted = 0;
    pulse_clr();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL full_fill c%0d: got %h required %h", i, obs, exp_vec);
      end
      advance();
    end
    drive(1'b1, 8'h35, 1'b0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready: got %b required 0", in_ready);
    end
    advance();
    for (int i = 0; i < 20; i++) begin
      drive(!accepted, 8'h35, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL full_drain c%0d: got %h required %h", i, obs, exp_vec);
      end
      if (i < 2) begin
        n_cmp++;
        if (in_ready !== (i == 1)) begin
          n_err++;
          $display("FAIL full_reaccept c%0d: ready=%b required %b", i, in_ready, i == 1);
        end
      end
      if (out_valid) got.push_back(out_data);
      if (in_ready) accepted = 1;
      advance();
    end
    n_cmp++;
    if (got.size() != 9 || got[0] !== 8'h30 || got[7] !== 8'h37 || got[8] !== 8'h35) begin
      n_err++;
      $display("FAIL full_order: got %0d bytes, last %h, required 9 bytes ending 35",
               got.size(), (got.size() > 0) ? got[got.size()-1] : 8'hxx);
    end
  endtask

  task automatic test_drop();
    logic [7:0] s [3] = '{8'hC1, 8'h32, 8'hFF};
    int n_out = 0;
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, (i < 3) ? s[i] : 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL drop_model c%0d: got %h required %h", i, obs, exp_vec);
      end
      if (out_valid) begin
        n_out++;
        n_cmp++;
        if (out_data !== 8'h32) begin
          n_err++;
          $display("FAIL drop_char: got %h required 32", out_data);
        end
      end
      advance();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (drop_cnt !== 8'd2 || n_out != 1) begin
      n_err++;
      $display("FAIL drop_cnt: got %0d/%0d chars required 2/1", drop_cnt, n_out);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [8] = '{"1", "+", "2", ";", "3", "-", "4", ";"};
    int gaps = 0, gap1 = -1, three = -1;
    pulse_clr();
    for (int i = 0; i < 14; i++) begin
      drive(i < 8, (i < 8) ? s[i] : 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL b2b_model c%0d: got %h required %h", i, obs, exp_vec);
      end
      if (frame_done) begin
        gaps++;
        if (gap1 < 0) gap1 = i;
        n_cmp++;
        if (frame_len !== 8'd4 || out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_len: got %0d valid %b required 4 0", frame_len, out_valid);
        end
      end
      if (out_valid && out_data == "3") three = i;
      advance();
    end
    n_cmp++;
    if (gaps != 2 || three != gap1 + 1) begin
      n_err++;
      $display("FAIL b2b_timing: gaps %0d three@%0d gap@%0d required 2 gaps, three one after",
               gaps, three, gap1);
    end
  endtask

  task automatic test_clr_mid();
    logic [7:0] s [3] = '{"1", "+", "1"};
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s[i], 1'b0, 1'b0);
      advance();
    end
    drive(1'b1, 8'h37, 1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL clr_mid: valid %b ready %b required 0 0", out_valid, in_ready);
    end
    advance();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || obs !== exp_vec) begin
      n_err++;
      $display("FAIL clr_after: got %h required %h", obs, exp_vec);
    end
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(i < 2, (i == 0) ? 8'h39 : 8'h3B, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL clr_frame c%0d: got %h required %h", i, obs, exp_vec);
      end
      if (i == 3) begin
        n_cmp++;
        if (frame_done !== 1'b1 || frame_len !== 8'd2) begin
          n_err++;
          $display("FAIL clr_len: done %b len %0d required 1 2", frame_done, frame_len);
        end
      end
      advance();
    end
  endtask

  task automatic test_ws();
    logic [7:0] s [6] = '{"1", " ", "+", " ", "1", ";"};
    int n_out = 0, flen = -1, want;
`ifdef STRIP_WS_EN
    want = 4;
`else
    want = 6;
`endif
    pulse_clr();
    for (int i = 0; i < 10; i++) begin
      drive(i < 6, (i < 6) ? s[i] : 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL ws_model c%0d: got %h required %h", i, obs, exp_vec);
      end
      if (out_valid) n_out++;
      if (frame_done) flen = int'(frame_len);
      advance();
    end
    n_cmp++;
    if (n_out != want || flen != want) begin
      n_err++;
      $display("FAIL ws_count: chars %0d len %0d required %0d", n_out, flen, want);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12] = '{"0", "5", "9", "+", "-", "*", "/", ";", " ", 8'h0A, 8'h41, 8'hC3};
    logic [7:0] d;
    logic v, r, c;
    for (int i = 0; i < 3000; i++) begin
      d = pool[$urandom_range(11)];
      v = ($urandom_range(3) != 0);
      r = ($urandom_range(9) < 6);
      c = ($urandom_range(299) == 0);
      drive(v, d, r, c);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL rand c%0d: got %h required %h", i, obs, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_full();
    test_drop();
    test_back_to_back();
    test_clr_mid();
    test_ws();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/char_stream_feeder.md
Name: char_stream_feeder

Overview:
- Upstream stage of the `string` expression-recognizer FSM.
- Accepts raw ASCII bytes from a producer over a valid/ready handshake and buffers them in a small show-ahead FIFO.
- Delivers one classified character per clock to the recognizer's 8-bit `in`, inserting a one-cycle gap and a frame report after each `;` terminator.
- Drives a neutral idle character whenever no data is available, so the recognizer never sees stale symbols.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- ADDR_W, 3: log2(DEPTH).
- IDLE_CHAR, 8'h00: value driven on out_data while out_valid=0.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  synchronous, active-high reset.
- in_valid  in  1  producer byte valid.
- in_data  in  8  producer byte.
- in_ready  out  1  high when a byte is accepted this cycle; equals !full & !clr.
- out_valid  out  1  FIFO head is presented.
- out_data  out  8  character to the recognizer; IDLE_CHAR when out_valid=0.
- out_class  out  2  00 other, 01 digit '0'-'9', 10 operator '+','-','*','/', 11 terminator ';'. Forced to 00 when out_valid=0.
- out_ready  in  1  consumer takes out_data this cycle; tied 1 when driving `string`.
- frame_done  out  1  one-cycle pulse in the GAP state.
- frame_len  out  8  characters consumed in the last frame, including ';'. Saturates at 255 and holds until the next frame_done.
- drop_cnt  out  8  saturating count of rejected bytes.

Behaviour:
- Reset: on a clr edge, pointers=0, count=0, state=IDLE, frame_len=0, drop_cnt=0, internal length counter=0.
  - While clr is high, in_ready=0 and writes are ignored.
  - Resulting outputs: out_valid=0, out_data=IDLE_CHAR, frame_done=0.
  - clr mid-frame discards all buffered bytes and the partial length.
- Write side:
  - A write occurs when in_valid & in_ready.
  - Bytes with bit7=1 are accepted (handshake completes) but not stored; drop_cnt increments, saturating at 255.
  - Otherwise the byte is stored at wr_ptr, and wr_ptr wraps mod DEPTH.
- Read side:
  - Show-ahead: out_data = mem[rd_ptr] combinationally when out_valid.
  - out_valid = (count != 0) & (state != GAP).
  - A read occurs when out_valid & out_ready; rd_ptr wraps mod DEPTH.
- Latency: a byte written at edge k is visible on out_data after edge k, provided the FIFO was empty and the state is not GAP.
- count is ADDR_W+1 bits.
  - Simultaneous write and read leaves count unchanged, including when full.
  - in_ready uses the registered full flag, so a write is refused when full even if a read happens in the same cycle. No bypass path.
- States:
  - IDLE: count=0. Goes to RUN on any stored write.
  - RUN: reads allowed. If a read consumes a class-11 byte, go to GAP. Else, if count becomes 0, go to IDLE.
  - GAP: exactly one cycle with out_valid=0, frame_done=1, and frame_len=final length. Then RUN if count!=0, else IDLE. Writes are still accepted during GAP.
- Length counter:
  - Increments on each read, saturating at 255.
  - Loads into frame_len when a ';' is read.
  - Clears to 0 at the GAP exit.
- Classification is purely combinational from out_data.

Optional Feature:
- Macro: STRIP_WS_EN.
- Defined: bytes 0x20, 0x09, 0x0A, 0x0D are accepted but not stored, and drop_cnt is not incremented.
- Undefined: whitespace is stored and delivered with class 00.

Test Plan:
- Reset then push "1+1;" (0x31, 0x2B, 0x31, 0x3B), out_ready=1 -> out_data sequence 31, 2B, 31, 3B with out_class 01, 10, 01, 11 on consecutive cycles; next cycle out_valid=0, out_data=00, frame_done=1, frame_len=4.
- Push 8 bytes with out_ready=0 -> in_ready=0 after the 8th; 9th byte (0x35) not accepted. Raise out_ready with in_valid held -> 0x35 accepted the cycle after the first read, and FIFO order is preserved across pointer wrap.
- Push 0xC1, '2', 0xFF -> drop_cnt=2; only 0x32 delivered.
- Push "1+2;3-4;" back-to-back -> GAP cycle between the frames; frame_len=4 at both frame_done pulses; '3' delivered the cycle after the first GAP.
- Push "1+1" then assert clr for one cycle mid-stream -> out_valid=0 and in_ready=0 during clr; after clr, count=0; the subsequent frame "9;" reports frame_len=2.
- With STRIP_WS_EN, push "1 + 1;" -> 4 characters delivered, frame_len=4. Without it -> 6 characters, spaces with class 00, frame_len=6.
